// File: rtl/subtree_launch_sequencer_if.sv
// Parent/child handshake bundle for subtree_launch_sequencer.
// slave = sequencer side, master = parent controller / child model side.
interface subtree_launch_sequencer_if #(
  parameter int NUM_CHILD = 5,
  parameter int IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) ();
  logic                 start_i;
  logic                 abort_i;
  logic [NUM_CHILD-1:0] mask_i;
  logic [NUM_CHILD-1:0] child_start_o;
  logic [NUM_CHILD-1:0] child_done_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 aborted_o;
  logic [IDX_W-1:0]     cur_idx_o;
  logic [NUM_CHILD-1:0] completed_o;
  logic                 error_o;

  modport slave (
    input  start_i, abort_i, mask_i, child_done_i,
    output child_start_o, busy_o, done_o, aborted_o, cur_idx_o, completed_o, error_o
  );

  modport master (
    output start_i, abort_i, mask_i, child_done_i,
    input  child_start_o, busy_o, done_o, aborted_o, cur_idx_o, completed_o, error_o
  );
endinterface

// File: rtl/subtree_launch_sequencer.sv
// Launches enabled children one at a time in ascending index order and reports done/abort.
// Optional WAIT watchdog enabled by defining SUBTREE_SEQ_WATCHDOG_EN.
module subtree_launch_sequencer #(
  parameter int NUM_CHILD      = 5,
  parameter int IDX_W          = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                       clk,
  input logic                       rst_n,
  subtree_launch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t               state, state_nxt;
  logic [NUM_CHILD-1:0] mask_q;
  logic [NUM_CHILD-1:0] completed_q;
  logic [IDX_W-1:0]     cur_idx;
  logic                 aborted_q;
  logic                 error_q;

  logic                 accept;
  logic                 load_idx;
  logic                 mark_done;
  logic                 kill;
  logic [IDX_W-1:0]     idx_nxt;
  logic [IDX_W:0]       first_set;
  logic [IDX_W:0]       next_set;
  logic                 wd_expired;

  // Lowest set bit of m at or above 'from'; MSB of the result flags "found".
  function automatic logic [IDX_W:0] find_set(input logic [NUM_CHILD-1:0] m, input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_CHILD - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_idx  = 1'b0;
    mark_done = 1'b0;
    kill      = 1'b0;
    idx_nxt   = cur_idx;
    first_set = find_set(bus.mask_i, 0);
    next_set  = find_set(mask_q, int'(cur_idx) + 1);
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          accept = 1'b1;
          if (first_set[IDX_W]) begin
            load_idx  = 1'b1;
            idx_nxt   = first_set[IDX_W-1:0];
            state_nxt = LAUNCH;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      LAUNCH: begin
        if (bus.abort_i) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Completion beats a same-cycle watchdog expiry; abort beats both.
        if (bus.abort_i) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (bus.child_done_i[cur_idx]) begin
          mark_done = 1'b1;
          if (next_set[IDX_W]) begin
            load_idx  = 1'b1;
            idx_nxt   = next_set[IDX_W-1:0];
            state_nxt = LAUNCH;
          end else begin
            state_nxt = FINISH;
          end
        end else if (wd_expired) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q      <= '0;
      completed_q <= '0;
      cur_idx     <= '0;
      aborted_q   <= 1'b0;
    end else begin
      aborted_q <= kill;
      if (accept) begin
        mask_q      <= bus.mask_i;
        completed_q <= '0;
      end
      if (load_idx)  cur_idx <= idx_nxt;
      if (mark_done) completed_q[cur_idx] <= 1'b1;
    end
  end

`ifdef SUBTREE_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout;

  // Expiry fires in the WAIT cycle that would bring the count to TIMEOUT_CYCLES.
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout    = (state == WAIT) && !bus.abort_i && !bus.child_done_i[cur_idx] && wd_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == LAUNCH)                                wd_cnt <= '0;
      else if ((state == WAIT) && !bus.child_done_i[cur_idx]) wd_cnt <= wd_cnt + 1'b1;
      if (accept)       error_q <= 1'b0;
      else if (timeout) error_q <= 1'b1;
    end
  end
`else
  logic [31:0] wd_unused;

  assign wd_unused  = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
  assign error_q    = 1'b0;
`endif

  assign bus.child_start_o = (state == LAUNCH) ? (NUM_CHILD'(1) << cur_idx) : '0;
  assign bus.busy_o        = (state != IDLE);
  assign bus.done_o        = (state == FINISH);
  assign bus.aborted_o     = aborted_q;
  assign bus.cur_idx_o     = cur_idx;
  assign bus.completed_o   = completed_q;
  assign bus.error_o       = error_q;
endmodule

// File: tb/tb_subtree_launch_sequencer.sv
// Bench for subtree_launch_sequencer: directed vector table, random run against a queue model,
// and a watchdog sequence when SUBTREE_SEQ_WATCHDOG_EN is defined.
module tb_subtree_launch_sequencer;
  localparam int NC = 5;
  localparam int IW = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  subtree_launch_sequencer_if #(.NUM_CHILD(NC), .IDX_W(IW)) bus ();

  subtree_launch_sequencer #(.NUM_CHILD(NC), .IDX_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n, start, abort;
    logic [NC-1:0] mask, done;
    logic [NC-1:0] e_cs;
    logic          e_busy, e_done, e_ab;
    logic [IW-1:0] e_idx;
    logic [NC-1:0] e_comp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic a, logic [NC-1:0] m, logic [NC-1:0] d,
                              logic [NC-1:0] cs, logic b, logic dn, logic ab,
                              logic [IW-1:0] idx, logic [NC-1:0] comp);
    vec_t v;
    v = '{r, s, a, m, d, cs, b, dn, ab, idx, comp};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs mid-cycle, then sample just after the next rising edge.
  task automatic step(input logic r, input logic s, input logic a,
                      input logic [NC-1:0] m, input logic [NC-1:0] d);
    @(negedge clk);
    rst_n            = r;
    bus.start_i      = s;
    bus.abort_i      = a;
    bus.mask_i       = m;
    bus.child_done_i = d;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of children still owed a launch, front is the current one.
  bit            m_run, m_launch, m_fin, m_ab, m_err;
  int            m_idx, m_wcnt;
  logic [NC-1:0] m_comp;
  int            m_q[$];

  task automatic model_step(input logic r, input logic s, input logic a,
                            input logic [NC-1:0] m, input logic [NC-1:0] d);
    bit ab;
    ab = 1'b0;
    if (!r) begin
      m_run = 0; m_launch = 0; m_fin = 0; m_err = 0; m_idx = 0; m_comp = '0; m_q.delete();
    end else if (!m_run) begin
      if (s) begin
        m_comp = '0;
        m_err  = 0;
        m_q.delete();
        for (int i = 0; i < NC; i++) if (m[i]) m_q.push_back(i);
        m_run = 1;
        if (m_q.size() == 0) m_fin = 1;
        else begin m_idx = m_q[0]; m_launch = 1; end
      end
    end else if (m_fin) begin
      m_run = 0; m_fin = 0;
    end else if (a) begin
      m_run = 0; m_launch = 0; ab = 1; m_q.delete();
    end else if (m_launch) begin
      m_launch = 0; m_wcnt = 0;
    end else if (d[m_idx]) begin
      m_comp[m_idx] = 1'b1;
      void'(m_q.pop_front());
      if (m_q.size() != 0) begin m_idx = m_q[0]; m_launch = 1; end
      else m_fin = 1;
    end else begin
`ifdef SUBTREE_SEQ_WATCHDOG_EN
      m_wcnt++;
      if (m_wcnt == TO) begin m_run = 0; ab = 1; m_err = 1; m_q.delete(); end
`endif
    end
    m_ab = ab;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic          r, s, a;
    logic [NC-1:0] m, d, e_cs;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.mask_i = '0; bus.child_done_i = '0;

    //            rst st ab mask      done     | cs       busy dn ab idx comp
    tbl.push_back(mk(0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 1, 0, 5'b10101, 5'b00000, 5'b00001, 1, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00001, 5'b00100, 1, 0, 0, 2, 5'b00001));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 2, 5'b00001));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 2, 5'b00001));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00100, 5'b10000, 1, 0, 0, 4, 5'b00101));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 4, 5'b00101));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 4, 5'b00101));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b10000, 5'b00000, 1, 1, 0, 4, 5'b10101));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 4, 5'b10101));
    tbl.push_back(mk(1, 1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 1, 0, 4, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 4, 5'b00000));
    tbl.push_back(mk(1, 1, 0, 5'b11111, 5'b00000, 5'b00001, 1, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00001, 5'b00010, 1, 0, 0, 1, 5'b00001));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 1, 5'b00001));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00010, 5'b00100, 1, 0, 0, 2, 5'b00011));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 2, 5'b00011));
    tbl.push_back(mk(1, 0, 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 1, 2, 5'b00011));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 2, 5'b00011));
    tbl.push_back(mk(1, 1, 0, 5'b11111, 5'b00000, 5'b00001, 1, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00001, 5'b00010, 1, 0, 0, 1, 5'b00001));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00010, 5'b00000, 1, 0, 0, 1, 5'b00001));
    tbl.push_back(mk(1, 1, 0, 5'b00000, 5'b01000, 5'b00000, 1, 0, 0, 1, 5'b00001));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b01001, 5'b00000, 1, 0, 0, 1, 5'b00001));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00010, 5'b00100, 1, 0, 0, 2, 5'b00011));
    tbl.push_back(mk(1, 0, 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 1, 2, 5'b00011));
    tbl.push_back(mk(1, 1, 1, 5'b00100, 5'b00000, 5'b00100, 1, 0, 0, 2, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b00000, 5'b00000, 5'b00000, 1, 0, 0, 2, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 1, 0, 5'b00000, 5'b00000, 5'b00000, 1, 1, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 5'b00000));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].start, tbl[i].abort, tbl[i].mask, tbl[i].done);
      chk($sformatf("row%0d child_start", i), 32'(bus.child_start_o), 32'(tbl[i].e_cs));
      chk($sformatf("row%0d busy", i),        32'(bus.busy_o),        32'(tbl[i].e_busy));
      chk($sformatf("row%0d done", i),        32'(bus.done_o),        32'(tbl[i].e_done));
      chk($sformatf("row%0d aborted", i),     32'(bus.aborted_o),     32'(tbl[i].e_ab));
      chk($sformatf("row%0d cur_idx", i),     32'(bus.cur_idx_o),     32'(tbl[i].e_idx));
      chk($sformatf("row%0d completed", i),   32'(bus.completed_o),   32'(tbl[i].e_comp));
      chk($sformatf("row%0d error", i),       32'(bus.error_o),       32'd0);
    end

`ifdef SUBTREE_SEQ_WATCHDOG_EN
    // Child 1 never answers: eight WAIT cycles, then abort with sticky error.
    step(1, 1, 0, 5'b00010, 5'b00000);
    chk("wd launch", 32'(bus.child_start_o), 32'h2);
    for (int k = 1; k <= TO; k++) begin
      step(1, 0, 0, 5'b00000, 5'b11101);
      chk($sformatf("wd wait%0d busy", k),  32'(bus.busy_o),  32'd1);
      chk($sformatf("wd wait%0d error", k), 32'(bus.error_o), 32'd0);
    end
    step(1, 0, 0, 5'b00000, 5'b00000);
    chk("wd aborted", 32'(bus.aborted_o), 32'd1);
    chk("wd error_set", 32'(bus.error_o), 32'd1);
    chk("wd busy_low", 32'(bus.busy_o), 32'd0);
    step(1, 0, 0, 5'b00000, 5'b00000);
    chk("wd aborted_pulse", 32'(bus.aborted_o), 32'd0);
    chk("wd error_sticky", 32'(bus.error_o), 32'd1);
    step(1, 1, 0, 5'b00000, 5'b00000);
    chk("wd error_clear", 32'(bus.error_o), 32'd0);
    chk("wd done", 32'(bus.done_o), 32'd1);
`endif

    m_idx = 0; m_wcnt = 0;
    model_step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 29) == 0);
      m = NC'($urandom);
      d = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
      model_step(r, s, a, m, d);
      step(r, s, a, m, d);
      e_cs = (m_run && m_launch) ? NC'(1 << m_idx) : '0;
      chk($sformatf("rand%0d outputs", c),
          {bus.child_start_o, bus.busy_o, bus.done_o, bus.aborted_o, bus.error_o,
           bus.cur_idx_o, bus.completed_o},
          {e_cs, m_run, m_fin, m_ab, m_err, IW'(m_idx), m_comp});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
